// File: rtl/alucont_pkg.sv
// Shared constants for the ALU control / multiply-divide block:
// funct codes, ALU control codes and the MDU state encoding.
package alucont_pkg;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;

    localparam logic [2:0] G_AND = 3'b000;
    localparam logic [2:0] G_OR  = 3'b001;
    localparam logic [2:0] G_ADD = 3'b010;
    localparam logic [2:0] G_XOR = 3'b011;
    localparam logic [2:0] G_NOR = 3'b100;
    localparam logic [2:0] G_SUB = 3'b110;
    localparam logic [2:0] G_SLT = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FIXUP = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mdu_core.sv
// Iterative multiply/divide engine: one shift-add or restoring-divide step per
// cycle on operand magnitudes, then a single sign-fixup cycle that writes HI/LO.
//
// state    | meaning
// ST_IDLE  | waiting for start; operands latched on start
// ST_BUSY  | WIDTH iterations, count runs WIDTH..1
// ST_FIXUP | apply result signs, drive hi_wr/lo_wr for one cycle
module mdu_core
    import alucont_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             hi_wr,
    output logic             lo_wr,
    output logic [WIDTH-1:0] hi_res,
    output logic [WIDTH-1:0] lo_res
);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] p_hi_q, p_hi_d;
    logic [WIDTH-1:0] p_lo_q, p_lo_d;
    logic             is_div_q, is_div_d;
    logic             neg_hi_q, neg_hi_d;
    logic             neg_lo_q, neg_lo_d;

    logic             sa, sb;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_diff;
    logic [2*WIDTH-1:0] prod, prod_neg;

    assign busy = (state_q != ST_IDLE);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        mcand_d  = mcand_q;
        p_hi_d   = p_hi_q;
        p_lo_d   = p_lo_q;
        is_div_d = is_div_q;
        neg_hi_d = neg_hi_q;
        neg_lo_d = neg_lo_q;
        hi_wr    = 1'b0;
        lo_wr    = 1'b0;
        hi_res   = p_hi_q;
        lo_res   = p_lo_q;

        // op[0] set means unsigned, op[1] set means divide (funct[1:0])
        sa       = ~op[0] & a[WIDTH-1];
        sb       = ~op[0] & b[WIDTH-1];
        add_sum  = {1'b0, p_hi_q} + (p_lo_q[0] ? {1'b0, mcand_q} : '0);
        rem_sh   = {p_hi_q, p_lo_q[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, mcand_q};
        prod     = {p_hi_q, p_lo_q};
        prod_neg = -prod;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_BUSY;
                    count_d  = CNT_W'(WIDTH);
                    p_hi_d   = '0;
                    p_lo_d   = sa ? -a : a;
                    mcand_d  = sb ? -b : b;
                    is_div_d = op[1];
                    neg_hi_d = op[1] ? sa : (sa ^ sb);
                    // Divide by zero leaves the all-ones quotient unsigned
                    neg_lo_d = (sa ^ sb) & ~(op[1] & (b == '0));
                end
            end
            ST_BUSY: begin
                count_d = count_q - 1'b1;
                if (is_div_q) begin
                    if (!rem_diff[WIDTH]) begin
                        p_hi_d = rem_diff[WIDTH-1:0];
                        p_lo_d = {p_lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        p_hi_d = rem_sh[WIDTH-1:0];
                        p_lo_d = {p_lo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    p_hi_d = add_sum[WIDTH:1];
                    p_lo_d = {add_sum[0], p_lo_q[WIDTH-1:1]};
                end
                if (count_q == CNT_W'(1)) begin
                    state_d = ST_FIXUP;
                end
            end
            ST_FIXUP: begin
                hi_wr   = 1'b1;
                lo_wr   = 1'b1;
                state_d = ST_IDLE;
                if (is_div_q) begin
                    hi_res = neg_hi_q ? -p_hi_q : p_hi_q;
                    lo_res = neg_lo_q ? -p_lo_q : p_lo_q;
                end else begin
                    {hi_res, lo_res} = neg_lo_q ? prod_neg : prod;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            mcand_q  <= '0;
            p_hi_q   <= '0;
            p_lo_q   <= '0;
            is_div_q <= 1'b0;
            neg_hi_q <= 1'b0;
            neg_lo_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            mcand_q  <= mcand_d;
            p_hi_q   <= p_hi_d;
            p_lo_q   <= p_lo_d;
            is_div_q <= is_div_d;
            neg_hi_q <= neg_hi_d;
            neg_lo_q <= neg_lo_d;
        end
    end

endmodule

// File: rtl/alucont_mdu.sv
// ALU control decode plus HI/LO register pair, MDU launch and pipeline stall.
module alucont_mdu
    import alucont_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic [1:0]       aluop,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic [2:0]       gout,
    output logic             hilo_sel,
    output logic [WIDTH-1:0] hilo_out,
    output logic             stall,
    output logic             busy
);

    logic             r_type, mdu_mul, mf_hi, mf_lo, mt_hi, mt_lo, mdu_fn;
    logic             core_busy, start, hi_wr, lo_wr;
    logic [WIDTH-1:0] hi_res, lo_res;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

    always_comb begin
        gout = G_ADD;
        case (aluop)
            2'b00: gout = G_ADD;
            2'b01: gout = G_SUB;
            2'b11: gout = G_OR;
            default: begin
                case (funct)
                    F_ADD, F_ADDU: gout = G_ADD;
                    F_SUB, F_SUBU: gout = G_SUB;
                    F_AND:         gout = G_AND;
                    F_OR:          gout = G_OR;
                    F_XOR:         gout = G_XOR;
                    F_NOR:         gout = G_NOR;
                    F_SLT, F_SLTU: gout = G_SLT;
                    default:       gout = G_ADD;
                endcase
            end
        endcase
    end

    assign r_type  = valid && (aluop == 2'b10);
    assign mdu_mul = r_type && (funct[5:2] == 4'b0110);
    assign mf_hi   = r_type && (funct == F_MFHI);
    assign mf_lo   = r_type && (funct == F_MFLO);
    assign mt_hi   = r_type && (funct == F_MTHI);
    assign mt_lo   = r_type && (funct == F_MTLO);
    assign mdu_fn  = mdu_mul || mf_hi || mf_lo || mt_hi || mt_lo;

    assign stall    = mdu_fn && core_busy;
    assign start    = mdu_mul && !core_busy;
    assign busy     = core_busy;
    // Reset also masks the write-back select so nothing is forwarded while held
    assign hilo_sel = rst_n && (mf_hi || mf_lo);
    assign hilo_out = mf_hi ? hi_q : (mf_lo ? lo_q : '0);

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (hi_wr) begin
            hi_d = hi_res;
        end else if (mt_hi && !core_busy) begin
            hi_d = rs_val;
        end
        if (lo_wr) begin
            lo_d = lo_res;
        end else if (mt_lo && !core_busy) begin
            lo_d = rs_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    mdu_core #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mdu_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (funct[1:0]),
        .a      (rs_val),
        .b      (rt_val),
        .busy   (core_busy),
        .hi_wr  (hi_wr),
        .lo_wr  (lo_wr),
        .hi_res (hi_res),
        .lo_res (lo_res)
    );

endmodule

// File: tb/tb_alucont_mdu.sv
// Self-checking bench for alucont_mdu: decode sweep, MDU results via a
// scoreboard of expected HI/LO pairs, stall timing, MTHI and async reset.
module tb_alucont_mdu;
    import alucont_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         valid = 1'b0;
    logic [1:0]   aluop = 2'b00;
    logic [5:0]   funct = 6'h00;
    logic [W-1:0] rs_val = '0;
    logic [W-1:0] rt_val = '0;
    logic [2:0]   gout;
    logic         hilo_sel;
    logic [W-1:0] hilo_out;
    logic         stall;
    logic         busy;

    int   n_pass = 0;
    int   n_checks = 0;
    res_t sb_q[$];

    alucont_mdu #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid    (valid),
        .aluop    (aluop),
        .funct    (funct),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .gout     (gout),
        .hilo_sel (hilo_sel),
        .hilo_out (hilo_out),
        .stall    (stall),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        res_t        r;
        longint      sp;
        logic [63:0] up;
        case (f)
            F_MULT: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                r.hi = sp[63:32];
                r.lo = sp[31:0];
            end
            F_MULTU: begin
                up = {32'b0, a} * {32'b0, b};
                r.hi = up[63:32];
                r.lo = up[31:0];
            end
            F_DIV: begin
                if (b == '0) begin
                    r.lo = '1;
                    r.hi = a;
                end else begin
                    sp = longint'($signed(a)) / longint'($signed(b));
                    r.lo = sp[31:0];
                    sp = longint'($signed(a)) % longint'($signed(b));
                    r.hi = sp[31:0];
                end
            end
            default: begin
                if (b == '0) begin
                    r.lo = '1;
                    r.hi = a;
                end else begin
                    r.lo = a / b;
                    r.hi = a % b;
                end
            end
        endcase
        return r;
    endfunction

    task automatic present(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        valid  = 1'b1;
        aluop  = 2'b10;
        funct  = f;
        rs_val = a;
        rt_val = b;
    endtask

    // Presents an MDU op in an idle cycle; returns on the first BUSY negedge
    task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        present(f, a, b);
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        #1;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        valid = 1'b1; aluop = 2'b10; funct = F_MFHI;
        #3;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
        n_checks++; if (stall !== 1'b0) $display("FAIL reset_stall got %b want 0", stall); else n_pass++;
        n_checks++; if (hilo_sel !== 1'b0) $display("FAIL reset_hilo_sel got %b want 0", hilo_sel); else n_pass++;
        n_checks++; if (hilo_out !== '0) $display("FAIL reset_hilo_out got %h want 0", hilo_out); else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        present(F_MFLO, '0, '0);
        #1;
        n_checks++; if (hilo_out !== '0) $display("FAIL reset_lo got %h want 0", hilo_out); else n_pass++;
        n_checks++; if (hilo_sel !== 1'b1) $display("FAIL reset_mflo_sel got %b want 1", hilo_sel); else n_pass++;
        @(negedge clk); valid = 1'b0;
    endtask

    task automatic test_decode;
        logic [5:0] fs[8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h3F};
        logic [2:0] gs[8] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b011, 3'b100, 3'b111, 3'b010};
        logic [1:0] ops[3] = '{2'b00, 2'b01, 2'b11};
        logic [2:0] og[3] = '{3'b010, 3'b110, 3'b001};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); aluop = 2'b10; funct = fs[i]; #1;
            n_checks++; if (gout !== gs[i]) $display("FAIL decode_f%h got %b want %b", fs[i], gout, gs[i]); else n_pass++;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); aluop = ops[i]; funct = 6'h24; #1;
            n_checks++; if (gout !== og[i]) $display("FAIL decode_op%b got %b want %b", ops[i], gout, og[i]); else n_pass++;
        end
    endtask

    task automatic test_mdu_ops;
        logic [5:0]   fs[6] = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_DIV, F_DIV};
        logic [W-1:0] as[6] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'd100, 32'd7, 32'hFFFFFFF8};
        logic [W-1:0] bs[6] = '{32'd7, 32'd7, 32'd2, 32'd0, 32'hFFFFFFFE, 32'd0};
        logic [W-1:0] eh[6] = '{32'hFFFFFFFF, 32'h6, 32'hFFFFFFFF, 32'd100, 32'd1, 32'hFFFFFFF8};
        logic [W-1:0] el[6] = '{32'hFFFFFFEB, 32'hFFFFFFEB, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF};
        logic [5:0]   f;
        logic [W-1:0] a, b;
        res_t         e;
        int           n;
        for (int i = 0; i < 14; i++) begin
            if (i < 6) begin
                f = fs[i]; a = as[i]; b = bs[i];
                e.hi = eh[i]; e.lo = el[i];
            end else begin
                f = F_MULT + 6'($urandom_range(0, 3));
                a = $urandom;
                b = ($urandom_range(0, 4) == 0) ? '0 : $urandom;
                if (i == 13) begin f = F_DIV; a = 32'h80000000; b = 32'hFFFFFFFF; end
                e = model(f, a, b);
            end
            sb_q.push_back(e);
            issue(f, a, b);
            wait_idle(n);
            n_checks++; if (n !== W + 1) $display("FAIL busy_len_%0d got %0d want %0d", i, n, W + 1); else n_pass++;
            e = sb_q.pop_front();
            present(F_MFHI, '0, '0); #1;
            n_checks++; if (hilo_out !== e.hi) $display("FAIL hi_%0d f=%h a=%h b=%h got %h want %h", i, f, a, b, hilo_out, e.hi); else n_pass++;
            present(F_MFLO, '0, '0); #1;
            n_checks++; if (hilo_out !== e.lo) $display("FAIL lo_%0d f=%h a=%h b=%h got %h want %h", i, f, a, b, hilo_out, e.lo); else n_pass++;
            @(negedge clk); valid = 1'b0;
        end
    endtask

    task automatic test_stall;
        res_t e;
        int   n;
        sb_q.push_back(model(F_MULT, 32'd12345, 32'hFFFF0003));
        issue(F_MULT, 32'd12345, 32'hFFFF0003);
        valid = 1'b1; aluop = 2'b10; funct = F_MFLO;
        n = 0; #1;
        while (stall && n < 200) begin
            n++;
            @(negedge clk); #1;
        end
        e = sb_q.pop_front();
        n_checks++; if (n !== W + 1) $display("FAIL stall_len got %0d want %0d", n, W + 1); else n_pass++;
        n_checks++; if (hilo_out !== e.lo) $display("FAIL stall_first_lo got %h want %h", hilo_out, e.lo); else n_pass++;
        @(negedge clk); valid = 1'b0;

        sb_q.push_back(model(F_MULTU, 32'd2, 32'd3));
        issue(F_MULTU, 32'd2, 32'd3);
        valid = 1'b1; aluop = 2'b10; funct = F_ADD; #1;
        n_checks++; if (stall !== 1'b0) $display("FAIL add_in_busy_stall got %b want 0", stall); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL add_in_busy_busy got %b want 1", busy); else n_pass++;
        n_checks++; if (gout !== G_ADD) $display("FAIL add_in_busy_gout got %b want %b", gout, G_ADD); else n_pass++;
        valid = 1'b0;
        wait_idle(n);
        e = sb_q.pop_front();
        present(F_MFLO, '0, '0); #1;
        n_checks++; if (hilo_out !== e.lo) $display("FAIL add_mult_lo got %h want %h", hilo_out, e.lo); else n_pass++;
        @(negedge clk); valid = 1'b0;
    endtask

    task automatic test_back_to_back;
        res_t e;
        int   n;
        issue(F_MULT, 32'd9, 32'd9);
        valid = 1'b1; aluop = 2'b10; funct = F_MULT; rs_val = 32'hFFFFFF00; rt_val = 32'h00000100;
        n = 0; #1;
        while (stall && n < 200) begin
            n++;
            @(negedge clk); #1;
        end
        n_checks++; if (n !== W + 1) $display("FAIL b2b_stall_len got %0d want %0d", n, W + 1); else n_pass++;
        sb_q.push_back(model(F_MULT, 32'hFFFFFF00, 32'h00000100));
        @(negedge clk); valid = 1'b0;
        wait_idle(n);
        n_checks++; if (n !== W + 1) $display("FAIL b2b_busy_len got %0d want %0d", n, W + 1); else n_pass++;
        e = sb_q.pop_front();
        present(F_MFHI, '0, '0); #1;
        n_checks++; if (hilo_out !== e.hi) $display("FAIL b2b_hi got %h want %h", hilo_out, e.hi); else n_pass++;
        present(F_MFLO, '0, '0); #1;
        n_checks++; if (hilo_out !== e.lo) $display("FAIL b2b_lo got %h want %h", hilo_out, e.lo); else n_pass++;
        @(negedge clk); valid = 1'b0;
    endtask

    task automatic test_mthi;
        res_t e;
        int   n;
        present(F_MTHI, 32'h1234, '0);
        present(F_MFHI, '0, '0); #1;
        n_checks++; if (hilo_out !== 32'h1234) $display("FAIL mthi_val got %h want 00001234", hilo_out); else n_pass++;
        n_checks++; if (hilo_sel !== 1'b1) $display("FAIL mthi_sel got %b want 1", hilo_sel); else n_pass++;
        sb_q.push_back(model(F_MULT, 32'd5, 32'd6));
        @(negedge clk); valid = 1'b0;
        issue(F_MULT, 32'd5, 32'd6);
        valid = 1'b1; aluop = 2'b10; funct = F_MTHI; rs_val = 32'hDEAD; #1;
        n_checks++; if (stall !== 1'b1) $display("FAIL mthi_busy_stall got %b want 1", stall); else n_pass++;
        present(F_MFHI, '0, '0); #1;
        n_checks++; if (hilo_out !== 32'h1234) $display("FAIL mthi_busy_hi got %h want 00001234", hilo_out); else n_pass++;
        valid = 1'b0;
        wait_idle(n);
        e = sb_q.pop_front();
        present(F_MFLO, '0, '0); #1;
        n_checks++; if (hilo_out !== e.lo) $display("FAIL mthi_mult_lo got %h want %h", hilo_out, e.lo); else n_pass++;
        @(negedge clk); valid = 1'b0;
    endtask

    task automatic test_async_reset;
        int n;
        present(F_MTLO, 32'hAAAA, '0);
        present(F_MTHI, 32'hBBBB, '0);
        issue(F_MULT, 32'd77, 32'd88);
        valid = 1'b1; aluop = 2'b10; funct = F_MFLO;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL arst_busy got %b want 0", busy); else n_pass++;
        n_checks++; if (stall !== 1'b0) $display("FAIL arst_stall got %b want 0", stall); else n_pass++;
        n_checks++; if (hilo_out !== '0) $display("FAIL arst_lo got %h want 0", hilo_out); else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        present(F_MFHI, '0, '0); #1;
        n_checks++; if (hilo_out !== '0) $display("FAIL arst_hi got %h want 0", hilo_out); else n_pass++;
        @(negedge clk); valid = 1'b0;
        sb_q.push_back(model(F_MULT, 32'd5, 32'd6));
        issue(F_MULT, 32'd5, 32'd6);
        wait_idle(n);
        present(F_MFLO, '0, '0); #1;
        n_checks++; if (hilo_out !== sb_q[0].lo || hilo_out !== 32'd30) $display("FAIL arst_mult_lo got %h want 0000001e", hilo_out); else n_pass++;
        void'(sb_q.pop_front());
        @(negedge clk); valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_decode();
        test_mdu_ops();
        test_stall();
        test_back_to_back();
        test_mthi();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alucont_mdu.md
# alucont_mdu

Parametrised ALU control unit with an integrated, iterative multiply/divide unit (MDU) and HI/LO register pair for the MIPS datapath. It decodes `aluop` and `funct` into the 3-bit ALU control code, adding XOR/NOR on top of the base R-type set. It runs MULT/MULTU/DIV/DIVU as multi-cycle operations, and asserts `stall` to freeze the PC when a later instruction depends on an in-flight MDU result. It sits between the main control unit and the ALU, beside the register file.

## Interface
- `WIDTH`, 32, datapath width; even, ≥4
- `CNT_W`, $clog2(WIDTH)+1, iteration counter width (derived)
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `valid`  in  1  instruction in decode/execute this cycle
- `aluop`  in  2  from main control
- `funct`  in  6  instruction[5:0]
- `rs_val`  in  WIDTH  register rs operand
- `rt_val`  in  WIDTH  register rt operand
- `gout`  out  3  ALU control code
- `hilo_sel`  out  1  high for MFHI/MFLO; write-back takes `hilo_out`
- `hilo_out`  out  WIDTH  HI for MFHI, LO for MFLO, else 0
- `stall`  out  1  hold PC and IF/ID this cycle
- `busy`  out  1  MDU state ≠ IDLE

## Operation
- `gout` (combinational):
  - `aluop` 00 → 010 (add); 01 → 110 (sub); 11 → 001 (ori).
  - `aluop` 10 decodes `funct`: 0x20/0x21 → 010; 0x22/0x23 → 110; 0x24 → 000; 0x25 → 001; 0x26 → 011 (xor); 0x27 → 100 (nor); 0x2A/0x2B → 111.
  - Any other `funct` → 010.
- MDU funct codes, acted on only when `valid` and `aluop`=10:
  - 0x10 MFHI, 0x11 MTHI, 0x12 MFLO, 0x13 MTLO.
  - 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU.
- FSM states IDLE, BUSY, FIXUP:
  - IDLE + MULT/MULTU/DIV/DIVU, no stall → latch |rs|, |rt| (raw values for unsigned ops), result sign flags, op type; count ← WIDTH; go to BUSY.
  - BUSY runs one iteration per cycle: shift-add multiply, or restoring divide. count decrements; at count=1 go to FIXUP.
  - FIXUP applies signs and writes HI/LO, then returns to IDLE.
    - MULT: HI:LO = 2·WIDTH-bit two's-complement product.
    - DIV: LO = quotient truncated toward zero; HI = remainder carrying the dividend's sign.
  - Divide by zero (signed or unsigned): LO = all ones, HI = dividend. No exception.
- MTHI/MTLO in IDLE write `rs_val` to HI/LO at the clock edge.
- `stall` = `valid` & `aluop`=10 & state≠IDLE & funct ∈ {MFHI, MFLO, MTHI, MTLO, MULT, MULTU, DIV, DIVU}.
  - Non-MDU instructions never stall.
  - A stalled instruction has no side effects and is re-presented by the pipeline.

## Timing
- Reset (asynchronous, `rst_n` low) → state IDLE, HI=0, LO=0, count=0, operand/accumulator registers 0.
  - `busy`=0, `stall`=0, `hilo_sel`=0, `hilo_out`=0 while `rst_n` low.
  - Reset mid-operation discards the operation; HI/LO become 0.
- Latency: an op accepted at edge E has HI/LO valid after edge E+WIDTH+1. `busy` is high for WIDTH+1 cycles.
- MFHI/MFLO presented on the first IDLE cycle sees the new values.
- Back-to-back MULT: the second stalls until IDLE, then is accepted on that cycle.
- MFLO in the FIXUP cycle stalls. The next cycle returns the updated LO.
- `hilo_out` and `gout` are combinational from current inputs and HI/LO. No output latency.

## Structure
- Package `alucont_pkg` holds:
  - `funct` localparams for all codes above.
  - `gout` code constants (ADD, SUB, AND, OR, XOR, NOR, SLT).
  - FSM state enum.
- Sub-module `mdu_core` holds the FSM, counter, iteration datapath and sign fixup. It exposes `start`, `op`, `a`, `b`, `busy`, `hi_wr`, `lo_wr`, `hi_res`, `lo_res`.
- Top level holds decode, HI/LO registers and stall logic.

## Test plan
- Decode sweep, `aluop`=10: `funct` 0x20 → 010; 0x22 → 110; 0x24 → 000; 0x25 → 001; 0x26 → 011; 0x27 → 100; 0x2A → 111; 0x3F → 010. `aluop` 00/01/11 → 010/110/001.
- MULT, rs=0xFFFFFFFD (−3), rt=7 → after 33 cycles HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULTU with the same operands → HI=0x00000006, LO=0xFFFFFFEB.
- DIV, rs=−7, rt=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU, rs=100, rt=0 → LO=0xFFFFFFFF, HI=100.
- MULT issued, then MFLO on every following cycle → `stall`=1 for exactly 33 cycles; first unstalled `hilo_out` equals the product LO. An ADD during BUSY → `stall`=0.
- MTHI 0x1234 in IDLE, then MFHI → `hilo_out`=0x1234, `hilo_sel`=1. MTHI during BUSY → stalled; HI unchanged.
- `rst_n` pulsed low mid-BUSY, asynchronous to `clk` → `busy`, `stall`, HI, LO at 0 immediately. After release, a fresh MULT 5×6 → LO=30.
